// File: rtl/lbr_controller_pkg.sv
// Shared definitions for the last-branch-record (LBR) controller.
// Contents: request encodings, transfer-type encodings, FSM state type,
// control-word bit positions and the transfer-type filter helper.
package lbr_controller_pkg;

  // lbrReq encodings from the control unit
  localparam logic [1:0] LBR_REQ_NONE = 2'b00;
  localparam logic [1:0] LBR_REQ_RD   = 2'b01;
  localparam logic [1:0] LBR_REQ_WR   = 2'b10;
  localparam logic [1:0] LBR_REQ_RSVD = 2'b11;

  // rec_type encodings of a retiring control transfer
  localparam logic [1:0] REC_BRANCH = 2'b00;
  localparam logic [1:0] REC_JAL    = 2'b01;
  localparam logic [1:0] REC_JALR   = 2'b10;
  localparam logic [1:0] REC_RSVD   = 2'b11;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_RESP  = 2'b10,
    ST_CLEAR = 2'b11
  } lbr_state_e;

  // Control-word (WRLBR wdata) bit positions
  localparam int CTL_ENABLE_BIT = 0;
  localparam int CTL_CLEAR_BIT  = 1;
  localparam int CTL_MASK_LSB   = 2;
  localparam int CTL_MASK_MSB   = 4;

  localparam logic [2:0] MASK_RESET = 3'b111;

  // A transfer passes the filter when its mask bit is set; the reserved
  // type never passes.
  function automatic logic rec_type_allowed(input logic [2:0] mask,
                                            input logic [1:0] rec_type);
    logic ok;
    case (rec_type)
      REC_BRANCH: ok = mask[0];
      REC_JAL:    ok = mask[1];
      REC_JALR:   ok = mask[2];
      REC_RSVD:   ok = 1'b0;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lbr_entry_ram.sv
// Branch-record storage: DEPTH x WIDTH, one write port, one registered read
// port. Read-during-write to the same address returns the old contents.
// Ports:
//   clock        - clock
//   we/waddr/wdata - write port
//   raddr        - read address, sampled every clock
//   rdata        - registered read data (one cycle after raddr)
module lbr_entry_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port (contents are not reset)
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/lbr_controller.sv
// Last-branch-record controller: captures retiring taken control transfers
// into a circular buffer and serves RDLBR/WRLBR requests from the control
// unit.
// Optional feature: define LBR_FILTER_EN to filter records by transfer type
// using the 3-bit mask from the control word.
// Ports:
//   clock, reset          - clock, asynchronous active-high reset
//   lbrReq, req_valid     - request type and qualifier (accepted only in IDLE)
//   req_index, req_sel    - RDLBR entry age (0 = newest), field (0 from, 1 to)
//   req_wdata             - WRLBR control word (bit0 enable, bit1 clear, 4:2 mask)
//   rec_valid, rec_type   - retiring transfer strobe and type
//   rec_from, rec_to      - source and target PC
//   rsp_valid/data/error  - one-cycle registered response
//   busy                  - stall request, high whenever not IDLE
//   lbr_count             - number of valid entries
module lbr_controller
  import lbr_controller_pkg::*;
#(
  parameter  int LBR_DEPTH  = 16,
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_W      = $clog2(LBR_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            lbrReq,
  input  logic                  req_valid,
  input  logic [IDX_W-1:0]      req_index,
  input  logic                  req_sel,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  rec_valid,
  input  logic [1:0]            rec_type,
  input  logic [DATA_WIDTH-1:0] rec_from,
  input  logic [DATA_WIDTH-1:0] rec_to,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_error,
  output logic                  busy,
  output logic [IDX_W:0]        lbr_count
);

  localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(LBR_DEPTH);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LBR_DEPTH - 1);

  lbr_state_e            state, nxt_state;
  logic [IDX_W-1:0]      head, nxt_head;
  logic [IDX_W:0]        nxt_count;
  logic                  enable, nxt_enable;
  logic [2:0]            mask, nxt_mask;
  logic [IDX_W-1:0]      clr_ptr, nxt_clr_ptr;
  logic                  rd_sel, nxt_rd_sel;
  logic                  rd_err, nxt_rd_err;
  logic                  nxt_rsp_valid, nxt_rsp_error, nxt_busy;
  logic [DATA_WIDTH-1:0] nxt_rsp_data;
  logic                  type_ok, rec_fire;

  logic                    ram_we;
  logic [IDX_W-1:0]        ram_waddr, ram_raddr;
  logic [2*DATA_WIDTH-1:0] ram_wdata, ram_rdata;

`ifdef LBR_FILTER_EN
  assign type_ok = rec_type_allowed(mask, rec_type);
  logic unused_wdata;
  assign unused_wdata = ^req_wdata[DATA_WIDTH-1:CTL_MASK_MSB+1];
`else
  assign type_ok = 1'b1;
  logic unused_filter;
  assign unused_filter = ^{rec_type, mask, req_wdata[DATA_WIDTH-1:CTL_MASK_MSB+1],
                           req_wdata[CTL_MASK_MSB:CTL_MASK_LSB]};
`endif

  // Records are dropped while disabled and for the whole clear sweep
  assign rec_fire = rec_valid && enable && type_ok && (state != ST_CLEAR);

  // Next-state, datapath updates and storage port control
  always_comb begin
    nxt_state     = state;
    nxt_head      = head;
    nxt_count     = lbr_count;
    nxt_enable    = enable;
    nxt_mask      = mask;
    nxt_clr_ptr   = clr_ptr;
    nxt_rd_sel    = rd_sel;
    nxt_rd_err    = rd_err;
    nxt_rsp_valid = 1'b0;
    nxt_rsp_error = 1'b0;
    nxt_rsp_data  = {DATA_WIDTH{1'b0}};
    ram_we        = 1'b0;
    ram_waddr     = head;
    ram_wdata     = {rec_from, rec_to};
    // Read address is launched in the accept cycle from the pre-record head,
    // so the RAM output is ready during READ.
    ram_raddr     = head - ONE_IDX - req_index;

    if (rec_fire) begin
      ram_we   = 1'b1;
      nxt_head = head + ONE_IDX;
      if (lbr_count != FULL_CNT) begin
        nxt_count = lbr_count + (IDX_W+1)'(1);
      end else begin
        nxt_count = lbr_count;
      end
    end else begin
      nxt_head = head;
    end

    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          case (lbrReq)
            LBR_REQ_RD: begin
              nxt_state  = ST_READ;
              nxt_rd_sel = req_sel;
              nxt_rd_err = ({1'b0, req_index} >= lbr_count);
            end
            LBR_REQ_WR: begin
              nxt_enable = req_wdata[CTL_ENABLE_BIT];
`ifdef LBR_FILTER_EN
              nxt_mask   = req_wdata[CTL_MASK_MSB:CTL_MASK_LSB];
`else
              nxt_mask   = mask;
`endif
              if (req_wdata[CTL_CLEAR_BIT]) begin
                nxt_state   = ST_CLEAR;
                nxt_clr_ptr = {IDX_W{1'b0}};
              end else begin
                nxt_rsp_valid = 1'b1;
              end
            end
            LBR_REQ_RSVD: begin
              nxt_rsp_valid = 1'b1;
              nxt_rsp_error = 1'b1;
            end
            default: nxt_state = ST_IDLE;
          endcase
        end else begin
          nxt_state = ST_IDLE;
        end
      end
      ST_READ: begin
        nxt_state     = ST_RESP;
        nxt_rsp_valid = 1'b1;
        nxt_rsp_error = rd_err;
        if (rd_err) begin
          nxt_rsp_data = {DATA_WIDTH{1'b0}};
        end else if (rd_sel) begin
          nxt_rsp_data = ram_rdata[DATA_WIDTH-1:0];
        end else begin
          nxt_rsp_data = ram_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
        end
      end
      ST_RESP: begin
        nxt_state = ST_IDLE;
      end
      ST_CLEAR: begin
        ram_we      = 1'b1;
        ram_waddr   = clr_ptr;
        ram_wdata   = {(2*DATA_WIDTH){1'b0}};
        nxt_clr_ptr = clr_ptr + ONE_IDX;
        if (clr_ptr == LAST_IDX) begin
          nxt_state     = ST_IDLE;
          nxt_head      = {IDX_W{1'b0}};
          nxt_count     = {(IDX_W+1){1'b0}};
          nxt_rsp_valid = 1'b1;
        end else begin
          nxt_state = ST_CLEAR;
        end
      end
      default: begin
        nxt_state = ST_IDLE;
      end
    endcase

    nxt_busy = (nxt_state != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      head      <= {IDX_W{1'b0}};
      lbr_count <= {(IDX_W+1){1'b0}};
      enable    <= 1'b0;
      mask      <= MASK_RESET;
      clr_ptr   <= {IDX_W{1'b0}};
      rd_sel    <= 1'b0;
      rd_err    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= {DATA_WIDTH{1'b0}};
      rsp_error <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= nxt_state;
      head      <= nxt_head;
      lbr_count <= nxt_count;
      enable    <= nxt_enable;
      mask      <= nxt_mask;
      clr_ptr   <= nxt_clr_ptr;
      rd_sel    <= nxt_rd_sel;
      rd_err    <= nxt_rd_err;
      rsp_valid <= nxt_rsp_valid;
      rsp_data  <= nxt_rsp_data;
      rsp_error <= nxt_rsp_error;
      busy      <= nxt_busy;
    end
  end

  lbr_entry_ram #(
    .DEPTH (LBR_DEPTH),
    .WIDTH (2*DATA_WIDTH),
    .AW    (IDX_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_lbr_controller.sv
// Scoreboard bench for lbr_controller (LBR_DEPTH=16, DATA_WIDTH=32).
// Stimulus pushes expected responses (data, error, cycle); a monitor pops and
// compares whenever rsp_valid is seen.
module tb_lbr_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  lbrReq;
  logic        req_valid;
  logic [3:0]  req_index;
  logic        req_sel;
  logic [31:0] req_wdata;
  logic        rec_valid;
  logic [1:0]  rec_type;
  logic [31:0] rec_from, rec_to;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        busy;
  logic [4:0]  lbr_count;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  lbr_controller #(.LBR_DEPTH(16), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .lbrReq(lbrReq), .req_valid(req_valid),
    .req_index(req_index), .req_sel(req_sel), .req_wdata(req_wdata),
    .rec_valid(rec_valid), .rec_type(rec_type), .rec_from(rec_from),
    .rec_to(rec_to), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .busy(busy), .lbr_count(lbr_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got data=0x%0h err=%0d at cycle %0d, none expected",
                   rsp_data, rsp_error, cyc);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", {32'h0, rsp_data}, {32'h0, e.data});
          chk("rsp_error", {63'h0, rsp_error}, {63'h0, e.err});
          chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rec(input logic [31:0] f, input logic [31:0] t, input logic [1:0] ty);
    tick();
    rec_valid = 1'b1; rec_from = f; rec_to = t; rec_type = ty;
  endtask

  task automatic rec_stop();
    tick();
    rec_valid = 1'b0;
  endtask

  task automatic rd(input int idx, input logic sel, input logic [31:0] d, input logic err);
    tick();
    lbrReq = 2'b01; req_valid = 1'b1; req_index = 4'(idx); req_sel = sel;
    sb.push_back('{d, err, cyc + 2});
    tick();
    req_valid = 1'b0; lbrReq = 2'b00;
    tick();
    tick();
  endtask

  task automatic wr(input logic [31:0] word);
    tick();
    lbrReq = 2'b10; req_valid = 1'b1; req_wdata = word;
    sb.push_back('{32'h0, 1'b0, cyc + 1});
    tick();
    req_valid = 1'b0; lbrReq = 2'b00;
    tick();
  endtask

  task automatic rsvd();
    tick();
    lbrReq = 2'b11; req_valid = 1'b1;
    sb.push_back('{32'h0, 1'b1, cyc + 1});
    tick();
    req_valid = 1'b0; lbrReq = 2'b00;
    tick();
  endtask

  task automatic clr(input logic [31:0] word);
    int c0;
    tick();
    lbrReq = 2'b10; req_valid = 1'b1; req_wdata = word;
    c0 = cyc;
    sb.push_back('{32'h0, 1'b0, c0 + 17});
    for (int i = 1; i <= 16; i++) begin
      tick();
      req_valid = 1'b0; lbrReq = 2'b00; rec_valid = 1'b0;
      chk("clr_busy", {63'h0, busy}, 64'h1);
      if (i == 5) begin
        rec_valid = 1'b1; rec_from = 32'hDEAD0000; rec_to = 32'hBEEF0000; rec_type = 2'b00;
      end
      if (i == 8) begin
        lbrReq = 2'b01; req_valid = 1'b1; req_index = 4'd0;
      end
    end
    tick();
    req_valid = 1'b0; lbrReq = 2'b00;
    chk("clr_busy_end", {63'h0, busy}, 64'h0);
    chk("clr_count", {59'h0, lbr_count}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; lbrReq = 2'b00; req_valid = 1'b0; req_index = 4'd0; req_sel = 1'b0;
    req_wdata = 32'h0; rec_valid = 1'b0; rec_type = 2'b00; rec_from = 32'h0; rec_to = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    chk("rst_count", {59'h0, lbr_count}, 64'h0);
    reset = 1'b0;

    // Recording disabled after reset
    rec(32'h10, 32'h20, 2'b00);
    rec_stop();
    chk("disabled_count", {59'h0, lbr_count}, 64'h0);

    // Enable, record three transfers, read back
    wr(32'h1);
    rec(32'h100, 32'h200, 2'b00);
    rec(32'h104, 32'h300, 2'b01);
    rec(32'h108, 32'h400, 2'b10);
    rec_stop();
    chk("count3", {59'h0, lbr_count}, 64'd3);
    rd(0, 1'b1, 32'h400, 1'b0);
    rd(0, 1'b0, 32'h108, 1'b0);
    rd(2, 1'b1, 32'h200, 1'b0);
    rd(1, 1'b0, 32'h104, 1'b0);
    rd(3, 1'b0, 32'h0, 1'b1);
    rsvd();
    chk("rsvd_count", {59'h0, lbr_count}, 64'd3);

    // Clear sweep with a record and a request issued mid-clear
    clr(32'h3);
    wr(32'h1D);
    rec(32'h500, 32'h600, 2'b00);
    rec(32'h504, 32'h604, 2'b00);
    rec_stop();
    chk("count2", {59'h0, lbr_count}, 64'd2);
    rd(5, 1'b0, 32'h0, 1'b1);
    rd(1, 1'b0, 32'h500, 1'b0);
    rd(0, 1'b1, 32'h604, 1'b0);

    // Wrap-around: 18 records into 16 entries
    clr(32'h1F);
    for (int i = 0; i < 18; i++) begin
      rec(32'h1000 + 32'(4 * i), 32'h2000 + 32'(4 * i), 2'b00);
    end
    rec_stop();
    chk("count_full", {59'h0, lbr_count}, 64'd16);
    rd(15, 1'b0, 32'h1008, 1'b0);
    rd(0, 1'b1, 32'h2044, 1'b0);

    // Record and read in the same cycle: read sees the pre-record snapshot
    tick();
    lbrReq = 2'b01; req_valid = 1'b1; req_index = 4'd0; req_sel = 1'b0;
    rec_valid = 1'b1; rec_from = 32'h3000; rec_to = 32'h3100; rec_type = 2'b00;
    sb.push_back('{32'h1044, 1'b0, cyc + 2});
    tick();
    req_valid = 1'b0; lbrReq = 2'b00; rec_valid = 1'b0;
    tick();
    tick();
    chk("count_sat", {59'h0, lbr_count}, 64'd16);
    rd(0, 1'b0, 32'h3000, 1'b0);
    rd(15, 1'b0, 32'h100C, 1'b0);

    // Transfer-type mask 001
    clr(32'h1F);
    wr(32'h5);
    rec(32'h700, 32'h800, 2'b00);
    rec(32'h710, 32'h810, 2'b01);
    rec(32'h720, 32'h820, 2'b10);
    rec(32'h730, 32'h830, 2'b11);
    rec_stop();
`ifdef LBR_FILTER_EN
    chk("filter_count", {59'h0, lbr_count}, 64'd1);
    rd(0, 1'b0, 32'h700, 1'b0);
    rd(1, 1'b0, 32'h0, 1'b1);
`else
    chk("nofilter_count", {59'h0, lbr_count}, 64'd4);
    rd(0, 1'b0, 32'h730, 1'b0);
    rd(3, 1'b0, 32'h700, 1'b0);
`endif

    // Reset asserted while in READ
    tick();
    lbrReq = 2'b01; req_valid = 1'b1; req_index = 4'd0; req_sel = 1'b0;
    tick();
    req_valid = 1'b0; lbrReq = 2'b00;
    chk("rr_busy_read", {63'h0, busy}, 64'h1);
    reset = 1'b1;
    #2;
    chk("rr_busy_async", {63'h0, busy}, 64'h0);
    @(negedge clock);
    chk("rr_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    chk("rr_count", {59'h0, lbr_count}, 64'h0);
    chk("rr_busy", {63'h0, busy}, 64'h0);
    tick();
    reset = 1'b0;
    rec(32'h900, 32'h910, 2'b00);
    rec_stop();
    chk("rr_disabled_count", {59'h0, lbr_count}, 64'h0);

    // Every expected response must have been seen
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    chk("sb_drain", 64'(sb.size()), 64'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
